vga_out: RTL and testbench

VGA_OUT -- requirements
Module: vga_out

---
 rtl/vga_out.sv | 200 ++++++++++++++++++++
 tb/tb_vga_out.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_out.sv
// ---------------------------------------------------------------------------
// vga_out -- 640x480@60 VGA timing generator with a monochrome 128x96
// framebuffer scaled up by SCALE in both axes.
//
// Optional feature: define VGA_OUT_BUSY_STALL_EN to make the fetch FSM honour
// SRAM_busy (FETCH is held until the memory accepts the read). Without it,
// SRAM_busy is ignored and every FETCH lasts exactly one clock.
//
// Ports:
//   clk               pixel clock (25.175 MHz nominal)
//   nrst              asynchronous active-low reset
//   SRAM_data_in      framebuffer word read at word_address_dest
//   SRAM_busy         memory cannot accept a read this cycle
//   data_en           read request (high while in FETCH)
//   word_address_dest framebuffer word address (row*4 + word in row)
//   byte_select       4'b1111 during FETCH, else 0
//   h_out / v_out     HSYNC / VSYNC, active low
//   pixel_data        monochrome pixel, 0 outside the active window
//   VGA_state         fetch FSM state (0 IDLE, 1 FETCH, 2 HOLD)
//   h_count / v_count clocks / lines elapsed in the current phase
//   h_state / v_state current phase (0 SYNC, 1 BACK, 2 ACTIVE, 3 FRONT)
// ---------------------------------------------------------------------------
module vga_out #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int SCALE    = 5
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] SRAM_data_in,
    input  logic        SRAM_busy,
    output logic        data_en,
    output logic [31:0] word_address_dest,
    output logic [3:0]  byte_select,
    output logic        h_out,
    output logic        v_out,
    output logic        pixel_data,
    output logic [1:0]  VGA_state,
    output logic [9:0]  h_count,
    output logic [8:0]  v_count,
    output logic [1:0]  h_state,
    output logic [1:0]  v_state
);

    typedef enum logic [1:0] {PH_SYNC = 2'd0, PH_BACK = 2'd1, PH_ACTIVE = 2'd2, PH_FRONT = 2'd3} phase_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_HOLD = 2'd2} fetch_t;

    // Three mid-line fetches (words 1..3 of a row) after the one in H BACK.
    localparam int ACT_TRIGS = 3;

    logic [9:0]  h_count_reg, h_count_next;
    logic [8:0]  v_count_reg, v_count_next;
    phase_t      h_state_reg, h_state_next;
    phase_t      v_state_reg, v_state_next;
    fetch_t      fetch_reg, fetch_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] word_reg;

    logic        h_last, line_end, enter_front, v_last;
    logic        trig_back, trig_any, capture, busy_eff;
    logic [ACT_TRIGS-1:0] trig_act;
    logic [1:0]  fetch_idx;
    logic [4:0]  pixel_bit;

    function automatic logic [9:0] h_len_m1(input phase_t p);
        case (p)
            PH_SYNC:   return 10'(H_SYNC - 1);
            PH_BACK:   return 10'(H_BACK - 1);
            PH_ACTIVE: return 10'(H_ACTIVE - 1);
            default:   return 10'(H_FRONT - 1);
        endcase
    endfunction

    function automatic logic [8:0] v_len_m1(input phase_t p);
        case (p)
            PH_SYNC:   return 9'(V_SYNC - 1);
            PH_BACK:   return 9'(V_BACK - 1);
            PH_ACTIVE: return 9'(V_ACTIVE - 1);
            default:   return 9'(V_FRONT - 1);
        endcase
    endfunction

`ifdef VGA_OUT_BUSY_STALL_EN
    assign busy_eff = SRAM_busy;
`else
    logic unused_busy;
    assign unused_busy = SRAM_busy;
    assign busy_eff    = 1'b0;
`endif

    // ---------------- timing counters ----------------
    assign h_last      = (h_count_reg == h_len_m1(h_state_reg));
    assign line_end    = h_last && (h_state_reg == PH_FRONT);
    assign enter_front = h_last && (h_state_reg == PH_ACTIVE);
    assign v_last      = (v_count_reg == v_len_m1(v_state_reg));

    always_comb begin
        h_count_next = h_count_reg + 10'd1;
        h_state_next = h_state_reg;
        v_count_next = v_count_reg;
        v_state_next = v_state_reg;
        if (h_last) begin
            h_count_next = 10'd0;
            h_state_next = phase_t'(h_state_reg + 2'd1);
        end
        if (line_end) begin
            if (v_last) begin
                v_count_next = 9'd0;
                v_state_next = phase_t'(v_state_reg + 2'd1);
            end else begin
                v_count_next = v_count_reg + 9'd1;
            end
        end
    end

    // ---------------- fetch triggers ----------------
    // Decoded one clock early so that FETCH is the registered state during
    // the trigger cycle itself, and the capture edge lands exactly where the
    // next 32-column group starts.
    assign trig_back = (h_state_reg == PH_BACK) && (h_count_reg == 10'(H_BACK - 2));

    genvar gi;
    generate
        for (gi = 0; gi < ACT_TRIGS; gi++) begin : g_trig
            assign trig_act[gi] = (h_state_reg == PH_ACTIVE) &&
                                  (h_count_reg == 10'((gi + 1) * 32 * SCALE - 2));
        end
    endgenerate

    assign trig_any = (v_state_reg == PH_ACTIVE) && (trig_back || (|trig_act));

    always_comb begin
        fetch_idx = 2'd0;
        for (int i = 0; i < ACT_TRIGS; i++) begin
            if (trig_act[i]) fetch_idx = 2'(i + 1);
        end
    end

    assign capture = (fetch_reg == ST_FETCH) && !busy_eff;

    always_comb begin
        fetch_next = fetch_reg;
        addr_next  = addr_reg;
        if (trig_any) begin
            fetch_next = ST_FETCH;
            addr_next  = (32'(v_count_reg / 9'(SCALE)) << 2) | 32'(fetch_idx);
        end else begin
            case (fetch_reg)
                ST_FETCH: if (!busy_eff)   fetch_next = ST_HOLD;
                ST_HOLD:  if (enter_front) fetch_next = ST_IDLE;
                ST_IDLE:  fetch_next = ST_IDLE;
                default:  fetch_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            h_count_reg <= 10'd0;
            v_count_reg <= 9'd0;
            h_state_reg <= PH_SYNC;
            v_state_reg <= PH_SYNC;
            fetch_reg   <= ST_IDLE;
            addr_reg    <= 32'd0;
            word_reg    <= 32'd0;
        end else begin
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
            h_state_reg <= h_state_next;
            v_state_reg <= v_state_next;
            fetch_reg   <= fetch_next;
            addr_reg    <= addr_next;
            if (capture) word_reg <= SRAM_data_in;
        end
    end

    // ---------------- outputs ----------------
    // MSB of each word is the leftmost pixel of its 32-column group.
    assign pixel_bit  = 5'd31 - 5'(h_count_reg / 10'(SCALE));
    assign pixel_data = (h_state_reg == PH_ACTIVE) && (v_state_reg == PH_ACTIVE) && word_reg[pixel_bit];

    assign data_en           = (fetch_reg == ST_FETCH);
    assign byte_select       = data_en ? 4'b1111 : 4'b0000;
    assign word_address_dest = addr_reg;
    assign VGA_state         = fetch_reg;
    assign h_out             = (h_state_reg != PH_SYNC);
    assign v_out             = (v_state_reg != PH_SYNC);
    assign h_count           = h_count_reg;
    assign v_count           = v_count_reg;
    assign h_state           = h_state_reg;
    assign v_state           = v_state_reg;

endmodule

// File: tb/tb_vga_out.sv
// ---------------------------------------------------------------------------
// tb_vga_out -- self-checking bench for vga_out (default build).
// Horizontal timing uses the real 800-clock line; the vertical phases are
// shortened (2/3/10/2 lines) so several complete frames fit in the run.
// The reference model derives everything from the number of clock edges since
// reset release: position in line = t mod 800, line = t / 800 mod 17.
// ---------------------------------------------------------------------------
module tb_vga_out;

    localparam int HS = 96, HB = 48, HA = 640, HF = 16;
    localparam int VS = 2, VB = 3, VA = 10, VF = 2, SC = 5;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int PASS_LEN = VT * HT + 6 * HT + 300;

    logic        tb_clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] SRAM_data_in;
    logic        SRAM_busy = 1'b0;
    logic        data_en, h_out, v_out, pixel_data;
    logic [31:0] word_address_dest;
    logic [3:0]  byte_select;
    logic [1:0]  VGA_state, h_state, v_state;
    logic [9:0]  h_count;
    logic [8:0]  v_count;

    logic [31:0] mem [0:383];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 tb_clk = ~tb_clk;

    assign SRAM_data_in = (word_address_dest < 32'd384) ? mem[word_address_dest[8:0]] : 32'd0;

    vga_out #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .SCALE(SC)
    ) dut (
        .clk(tb_clk), .nrst(nrst), .SRAM_data_in(SRAM_data_in), .SRAM_busy(SRAM_busy),
        .data_en(data_en), .word_address_dest(word_address_dest), .byte_select(byte_select),
        .h_out(h_out), .v_out(v_out), .pixel_data(pixel_data), .VGA_state(VGA_state),
        .h_count(h_count), .v_count(v_count), .h_state(h_state), .v_state(v_state)
    );

    typedef struct {
        int         n;
        logic [1:0] hs;
        logic [9:0] hc;
        logic [1:0] vs;
        logic [8:0] vc;
        logic       ho;
        logic       vo;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge tb_clk);
        @(negedge tb_clk);
    endtask

    task automatic release_reset();
        @(negedge tb_clk);
        nrst = 1'b0;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        nrst = 1'b1;
    endtask

    // Expected outputs after t edges since release, from the timing rules.
    task automatic model(input int t, output logic [32:0] v, output logic [31:0] a, output logic en);
        int h, ln, hs, hc, vs, vc, c, r;
        logic [31:0] w;
        logic pix;
        logic [1:0] fs;
        h  = t % HT;
        ln = (t / HT) % VT;
        if (h < HS)                begin hs = 0; hc = h;                end
        else if (h < HS + HB)      begin hs = 1; hc = h - HS;           end
        else if (h < HS + HB + HA) begin hs = 2; hc = h - HS - HB;      end
        else                       begin hs = 3; hc = h - HS - HB - HA; end
        if (ln < VS)                begin vs = 0; vc = ln;                end
        else if (ln < VS + VB)      begin vs = 1; vc = ln - VS;           end
        else if (ln < VS + VB + VA) begin vs = 2; vc = ln - VS - VB;      end
        else                        begin vs = 3; vc = ln - VS - VB - VA; end
        r   = vc / SC;
        pix = 1'b0;
        if (hs == 2 && vs == 2) begin
            c   = hc / SC;
            w   = mem[r * 4 + c / 32];
            pix = w[31 - (c % 32)];
        end
        en = (vs == 2) && ((hs == 1 && hc == HB - 1) ||
                           (hs == 2 && (hc == 159 || hc == 319 || hc == 479)));
        a  = en ? 32'(r * 4 + ((hs == 1) ? 0 : (hc + 1) / 160)) : 32'd0;
        fs = en ? 2'd1 : ((vs == 2 && hs == 2) ? 2'd2 : 2'd0);
        v  = {2'(hs), 10'(hc), 2'(vs), 9'(vc), 1'(hs != 0), 1'(vs != 0), pix, en,
              (en ? 4'hF : 4'h0), fs};
    endtask

    logic [32:0] exp_v, act_v;
    logic [31:0] exp_a;
    logic        exp_en;
    int          cur, hlow, vlow, hh, ln;

    initial begin
        tbl[0]  = '{1,     2'd0, 10'd1,   2'd0, 9'd0, 1'b0, 1'b0};
        tbl[1]  = '{95,    2'd0, 10'd95,  2'd0, 9'd0, 1'b0, 1'b0};
        tbl[2]  = '{96,    2'd1, 10'd0,   2'd0, 9'd0, 1'b1, 1'b0};
        tbl[3]  = '{143,   2'd1, 10'd47,  2'd0, 9'd0, 1'b1, 1'b0};
        tbl[4]  = '{144,   2'd2, 10'd0,   2'd0, 9'd0, 1'b1, 1'b0};
        tbl[5]  = '{783,   2'd2, 10'd639, 2'd0, 9'd0, 1'b1, 1'b0};
        tbl[6]  = '{784,   2'd3, 10'd0,   2'd0, 9'd0, 1'b1, 1'b0};
        tbl[7]  = '{799,   2'd3, 10'd15,  2'd0, 9'd0, 1'b1, 1'b0};
        tbl[8]  = '{800,   2'd0, 10'd0,   2'd0, 9'd1, 1'b0, 1'b0};
        tbl[9]  = '{1600,  2'd0, 10'd0,   2'd1, 9'd0, 1'b0, 1'b1};
        tbl[10] = '{4000,  2'd0, 10'd0,   2'd2, 9'd0, 1'b0, 1'b1};
        tbl[11] = '{11200, 2'd0, 10'd0,   2'd2, 9'd9, 1'b0, 1'b1};
        tbl[12] = '{12000, 2'd0, 10'd0,   2'd3, 9'd0, 1'b0, 1'b1};
        tbl[13] = '{13599, 2'd3, 10'd15,  2'd3, 9'd1, 1'b1, 1'b1};
        tbl[14] = '{13600, 2'd0, 10'd0,   2'd0, 9'd0, 1'b0, 1'b0};
        for (int i = 0; i < 384; i++) mem[i] = 32'd0;

        // Reset held for two clocks: every output at its reset value.
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        chk("rst_counters", {h_state, h_count, v_state, v_count}, 64'd0);
        chk("rst_sync", {h_out, v_out}, 64'd0);
        chk("rst_fetch", {VGA_state, data_en, byte_select}, 64'd0);
        chk("rst_addr", word_address_dest, 64'd0);
        chk("rst_pixel", pixel_data, 64'd0);
        nrst = 1'b1;

        // Timing landmarks across one full frame.
        cur = 0;
        for (int i = 0; i < 15; i++) begin
            while (cur < tbl[i].n) begin
                step();
                cur++;
            end
            chk($sformatf("timing_n%0d", tbl[i].n),
                {h_state, h_count, v_state, v_count, h_out, v_out},
                {tbl[i].hs, tbl[i].hc, tbl[i].vs, tbl[i].vc, tbl[i].ho, tbl[i].vo});
        end

        // Pass 0: alternating-pattern memory; pass 1: random memory.
        // SRAM_busy toggles randomly and must have no effect in this build.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 384; i++)
                mem[i] = (p == 0) ? ((i % 2 == 0) ? 32'hAAAAAAAA : 32'h11111111) : $urandom;
            release_reset();
            hlow = 0;
            vlow = 0;
            for (int t = 0; t < PASS_LEN; t++) begin
                model(t, exp_v, exp_a, exp_en);
                act_v = {h_state, h_count, v_state, v_count, h_out, v_out, pixel_data,
                         data_en, byte_select, VGA_state};
                chk($sformatf("cycle_p%0d_t%0d", p, t), 64'(act_v), 64'(exp_v));
                if (exp_en) chk($sformatf("addr_p%0d_t%0d", p, t), word_address_dest, exp_a);
                hh = t % HT;
                ln = t / HT;
                if (p == 0 && ln == VS + VB && hh >= HS + HB && hh < HS + HB + 160)
                    chk("row0_alternate", pixel_data, 64'(((hh - HS - HB) / SC) % 2 == 0));
                if (t < HT && !h_out) hlow++;
                if (t < VT * HT && !v_out) vlow++;
                SRAM_busy = 1'($urandom_range(0, 1));
                step();
            end
            chk("hsync_low_clocks", hlow, 64'd96);
            chk("vsync_low_clocks", vlow, 64'(VS * HT));
        end

        // Asynchronous reset in the middle of an active line.
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_counters", {h_state, h_count, v_state, v_count}, 64'd0);
        chk("async_rst_outs", {h_out, v_out, pixel_data, data_en, byte_select, VGA_state}, 64'd0);
        chk("async_rst_addr", word_address_dest, 64'd0);
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        nrst = 1'b1;
        chk("release_hold", {h_state, h_count, v_state, v_count}, 64'd0);
        step();
        chk("release_first_edge", {h_state, h_count, v_state, v_count}, {2'd0, 10'd1, 2'd0, 9'd0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
